uart_ins_loader: RTL



---
 rtl/uart_ins_loader_if.sv | 16 +
 rtl/uart_ins_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_ins_loader_if.sv
// Instruction-memory write port plus loader status, driven by uart_ins_loader
// (master) and consumed by the memory / board logic (slave).
interface uart_ins_loader_if #(
  parameter int ADDR_W = 6
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  modport master (output wr_en, wr_addr, wr_data, cpu_hold, done, err, err_code);
  modport slave  (input  wr_en, wr_addr, wr_data, cpu_hold, done, err, err_code);
endinterface

// File: rtl/uart_ins_loader.sv
// Serial program loader: 8N1 UART receiver feeding a length/words/checksum
// protocol that writes 32-bit words into instruction memory.
module uart_ins_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  uart_ins_loader_if.master bus
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam int               MAX_WORDS = 1 << ADDR_W;

  // Synchronizer; rx_prev_q gives the falling-edge detector its history.
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             start_ok_q, byte_valid_q, frame_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q   <= RX_IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      start_ok_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      start_ok_q   <= 1'b0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            clk_cnt_q  <= '0;
          end
        end
        RX_START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              bit_idx_q  <= '0;
              start_ok_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_sync_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q  <= '0;
            rx_state_q <= RX_IDLE;
            if (rx_sync_q) byte_valid_q <= 1'b1;
            else           frame_err_q  <= 1'b1;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

  ld_state_t         ld_state_q;
  logic [ADDR_W:0]   n_q, word_cnt_q;
  logic [1:0]        byte_idx_q;
  logic [23:0]       word_q;
  logic [7:0]        csum_q, csum_d;
  logic              wr_en_q, cpu_hold_q, done_q, err_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic [1:0]        err_code_q;
  logic              len_ok, receiving;

  assign csum_d    = csum_q + shift_q;
  assign len_ok    = (shift_q != 8'd0) && (int'(shift_q) <= MAX_WORDS);
  assign receiving = (ld_state_q == L_LEN) || (ld_state_q == L_DATA) || (ld_state_q == L_CSUM);

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q <= L_IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      wr_en_q <= 1'b0;
      if (frame_err_q && receiving) begin
        ld_state_q <= L_ERR;
        cpu_hold_q <= 1'b0;
        err_q      <= 1'b1;
        err_code_q <= 2'b01;
      end else begin
        case (ld_state_q)
          L_IDLE, L_DONE, L_ERR: begin
            if (start_ok_q) begin
              ld_state_q <= L_LEN;
              cpu_hold_q <= 1'b1;
              done_q     <= 1'b0;
              err_q      <= 1'b0;
              err_code_q <= 2'b00;
            end
          end
          L_LEN: begin
            if (byte_valid_q) begin
              if (len_ok) begin
                ld_state_q <= L_DATA;
                n_q        <= (ADDR_W + 1)'(shift_q);
                word_cnt_q <= '0;
                byte_idx_q <= '0;
                csum_q     <= '0;
              end else begin
                ld_state_q <= L_ERR;
                cpu_hold_q <= 1'b0;
                err_q      <= 1'b1;
                err_code_q <= 2'b10;
              end
            end
          end
          L_DATA: begin
            if (byte_valid_q) begin
              csum_q     <= csum_d;
              byte_idx_q <= byte_idx_q + 2'd1;
              // Little-endian: earlier bytes sit in the low lanes of word_q.
              if (byte_idx_q == 2'd3) begin
                wr_en_q    <= 1'b1;
                wr_addr_q  <= word_cnt_q[ADDR_W-1:0];
                wr_data_q  <= {shift_q, word_q};
                word_cnt_q <= word_cnt_q + 1'b1;
                if (word_cnt_q == n_q - 1'b1) ld_state_q <= L_CSUM;
              end else begin
                word_q <= {shift_q, word_q[23:8]};
              end
            end
          end
          L_CSUM: begin
            if (byte_valid_q) begin
              cpu_hold_q <= 1'b0;
              if (shift_q == csum_q) begin
                ld_state_q <= L_DONE;
                done_q     <= 1'b1;
              end else begin
                ld_state_q <= L_ERR;
                err_q      <= 1'b1;
                err_code_q <= 2'b11;
              end
            end
          end
          default: ld_state_q <= L_IDLE;
        endcase
      end
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cpu_hold = cpu_hold_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule
